// File: rtl/music_pkg.sv
// Shared definitions for the music note player: note codes, tone frequency table,
// FSM state type and the tone half-period helper.
package music_pkg;

    localparam logic [4:0] S  = 5'd0;
    localparam logic [4:0] C4 = 5'd1;
    localparam logic [4:0] D4 = 5'd2;
    localparam logic [4:0] E4 = 5'd3;
    localparam logic [4:0] F4 = 5'd4;
    localparam logic [4:0] G4 = 5'd5;
    localparam logic [4:0] A4 = 5'd6;
    localparam logic [4:0] B4 = 5'd7;
    localparam logic [4:0] C5 = 5'd8;
    localparam logic [4:0] D5 = 5'd9;
    localparam logic [4:0] E5 = 5'd10;
    localparam logic [4:0] F5 = 5'd11;
    localparam logic [4:0] G5 = 5'd12;
    localparam logic [4:0] A5 = 5'd13;
    localparam logic [4:0] B5 = 5'd14;
    localparam logic [4:0] C6 = 5'd15;

    localparam int unsigned NOTE_FREQ_HZ [16] = '{
        0,   262, 294, 330, 349, 392, 440, 494,
        523, 587, 659, 698, 784, 880, 988, 1047
    };

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    function automatic int unsigned half_period(input int unsigned clk_hz, input logic [4:0] code);
        int unsigned freq;
        int unsigned half;
        freq = (code > C6) ? 0 : NOTE_FREQ_HZ[code[3:0]];
        // A rest never toggles; returning 1 keeps the terminal-count compare well defined.
        if (freq == 0) return 1;
        half = clk_hz / (2 * freq);
        return (half == 0) ? 1 : half;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator for the currently sounding note; restarts the wave
// from low on every note change and stays silent on a rest.
module tone_divider
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] cur_note,
    output logic       audio
);

    logic [4:0]  prev_note_q, prev_note_d;
    logic [31:0] div_q, div_d, div_eff, half;
    logic        audio_q, audio_d, audio_eff, note_changed;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_note_q <= S;
            div_q       <= '0;
            audio_q     <= 1'b0;
        end else begin
            prev_note_q <= prev_note_d;
            div_q       <= div_d;
            audio_q     <= audio_d;
        end
    end

    // A note change zeroes divider and output in the very cycle the new note appears.
    always_comb begin
        half         = half_period(CLK_HZ, cur_note);
        note_changed = (cur_note != prev_note_q);
        div_eff      = note_changed ? '0 : div_q;
        audio_eff    = note_changed ? 1'b0 : audio_q;
        prev_note_d  = cur_note;
        div_d        = div_eff + 32'd1;
        audio_d      = audio_eff;
        if (cur_note == S) begin
            div_d   = '0;
            audio_d = 1'b0;
        end else if (div_eff == half - 32'd1) begin
            div_d   = '0;
            audio_d = ~audio_eff;
        end
    end

    assign audio = audio_eff;

endmodule

// File: rtl/music_note_player.sv
// Beat sequencer and tone output for the song player. Define MUSIC_LOOP_EN to
// wrap the song endlessly instead of stopping with a done pulse.
module music_note_player
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned SONG_LEN    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [4:0]  note,
    output logic [31:0] beat_cnt,
    output logic [4:0]  cur_note,
    output logic        busy,
    output logic        done,
    output logic        audio
);

    state_t      state_q, state_d;
    logic [31:0] beat_tmr_q, beat_tmr_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [4:0]  cur_note_q, cur_note_d;
    logic        done_q, done_d;
    logic        beat_tick, last_beat, song_end;

    assign beat_tick = (state_q == PLAY) && (beat_tmr_q == 32'(BEAT_CYCLES - 1));
    assign last_beat = (beat_cnt_q == 32'(SONG_LEN - 1));
`ifdef MUSIC_LOOP_EN
    assign song_end  = 1'b0;
`else
    assign song_end  = beat_tick && last_beat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_tmr_q <= '0;
            beat_cnt_q <= '0;
            cur_note_q <= S;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_tmr_q <= beat_tmr_d;
            beat_cnt_q <= beat_cnt_d;
            cur_note_q <= cur_note_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = PLAY;
            PLAY:    if (stop || song_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Everything falls back to its reset value whenever PLAY is not continuing.
        beat_tmr_d = '0;
        beat_cnt_d = '0;
        cur_note_d = S;
        if (state_q == PLAY && state_d == PLAY) begin
            beat_tmr_d = beat_tick ? '0 : beat_tmr_q + 32'd1;
            beat_cnt_d = beat_cnt_q;
            if (beat_tick) beat_cnt_d = last_beat ? '0 : beat_cnt_q + 32'd1;
            cur_note_d = (note > C6) ? S : note;
        end
        done_d = (state_q == PLAY) && !stop && song_end;
    end

    always_comb begin
        busy     = (state_q == PLAY);
        done     = done_q;
        beat_cnt = beat_cnt_q;
        cur_note = cur_note_q;
    end

    tone_divider #(
        .CLK_HZ(CLK_HZ)
    ) u_tone (
        .clk     (clk),
        .rst     (rst),
        .cur_note(cur_note_q),
        .audio   (audio)
    );

endmodule

// File: tb/tb_music_note_player.sv
// Directed bench for music_note_player with a score model that returns note = beat_cnt.
module tb_music_note_player;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned BEAT_CYCLES = 4000;
    localparam int unsigned SONG_LEN    = 16;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [4:0]  note;
    logic [31:0] beat_cnt;
    logic [4:0]  cur_note;
    logic        busy, done, audio;
    logic        ovr_en;
    logic [4:0]  ovr_val;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc_ctr   = 0;
    int unsigned done_seen = 0;
    int exp_beat_q[$];
    int exp_half_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;
    always @(negedge clk) done_seen <= done_seen + (done ? 1 : 0);

    assign note = ovr_en ? ovr_val : beat_cnt[4:0];

    music_note_player #(
        .CLK_HZ     (CLK_HZ),
        .BEAT_CYCLES(BEAT_CYCLES),
        .SONG_LEN   (SONG_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .note    (note),
        .beat_cnt(beat_cnt),
        .cur_note(cur_note),
        .busy    (busy),
        .done    (done),
        .audio   (audio)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_beat_cnt"}, beat_cnt, 0);
        check({tag, "_cur_note"}, cur_note, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_audio"}, audio, 0);
    endtask

    task automatic pulse(input logic s, input logic p);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, a_hi, act, exp_v;
        int unsigned t0, d0;
        logic [31:0] prev;

        rst = 1'b1; start = 1'b0; stop = 1'b0; ovr_en = 1'b0; ovr_val = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || done || audio || beat_cnt != 0 || cur_note != 0) act++;
        end
        check("idle_activity", act, 0);
        check_all_quiet("reset");

        // Full song: beat sequence, rest beat, A4 and C6 tones, end of song.
        for (int b = 1; b < int'(SONG_LEN); b++) exp_beat_q.push_back(b);
        exp_beat_q.push_back(0);
        exp_half_q.push_back(1136);
        exp_half_q.push_back(477);

        pulse(1'b1, 1'b0);
        check("start_busy", busy, 1);
        check("start_beat_cnt", beat_cnt, 0);
        t0 = cyc_ctr;
        for (int b = 0; b < int'(SONG_LEN); b++) begin
            if (b == 6 || b == 15) begin
                @(negedge clk);
                check("tone_cur_note", cur_note, b);
                exp_v = exp_half_q.size() ? exp_half_q.pop_front() : -1;
                n = 1;
                while (!audio && n < 3000) begin @(negedge clk); n++; end
                check("tone_first_rise", n, exp_v + 1);
                n = 0;
                while (audio && n < 3000) begin @(negedge clk); n++; end
                check("tone_half", n, exp_v);
            end
            a_hi = 0; n = 0; prev = beat_cnt;
            while (beat_cnt == prev && n < int'(BEAT_CYCLES) + 100) begin
                @(negedge clk);
                n++;
                if (audio) a_hi++;
            end
            if (b == 0) check("rest_audio_high_cycles", a_hi, 0);
            check("beat_interval", cyc_ctr - t0, BEAT_CYCLES);
            t0 = cyc_ctr;
            exp_v = exp_beat_q.size() ? exp_beat_q.pop_front() : -1;
            check("beat_seq", beat_cnt, exp_v);
        end
`ifdef MUSIC_LOOP_EN
        check("loop_busy", busy, 1);
        check("loop_done", done, 0);
        @(negedge clk);
        check("loop_done_seen", done_seen, 0);
        pulse(1'b0, 1'b1);
        check("loop_stop_busy", busy, 0);
`else
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_cur_note", cur_note, 0);
        check("end_audio", audio, 0);
        @(negedge clk);
        check("end_done_one_cycle", done, 0);
        check("end_done_seen", done_seen, 1);
`endif

        // Mid-song stop with simultaneous start, start while busy, out-of-range code.
        pulse(1'b1, 1'b0);
        check("run2_busy", busy, 1);
        repeat (4200) @(negedge clk);
        check("run2_beat", beat_cnt, 1);
        pulse(1'b1, 1'b0);
        check("start_while_busy_beat", beat_cnt, 1);
        check("start_while_busy_busy", busy, 1);
        ovr_en = 1'b1; ovr_val = 5'd20;
        repeat (2) @(negedge clk);
        check("code_over_15_note", cur_note, 0);
        check("code_over_15_audio", audio, 0);
        ovr_en = 1'b0;
        repeat (300) @(negedge clk);
        check("code_restored", cur_note, 1);
        d0 = done_seen;
        pulse(1'b1, 1'b1);
        check_all_quiet("stop");
        repeat (20) @(negedge clk);
        check("stop_stays_idle", busy, 0);
        pulse(1'b1, 1'b1);
        check("idle_start_stop_busy", busy, 0);
        check("stop_no_done", done_seen, d0);

        // Restart from beat 0, then reset mid-tone with start held.
        pulse(1'b1, 1'b0);
        check("restart_busy", busy, 1);
        check("restart_beat", beat_cnt, 0);
        repeat (6500) @(negedge clk);
        check("pre_rst_beat", beat_cnt, 1);
        check("pre_rst_audio", audio, 1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_all_quiet("rst");
        @(negedge clk);
        check("rst_start_ignored", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
